// File: rtl/regwb_buffer.sv
// Four-entry register-writeback FIFO with youngest-match bypass to the decode read ports.
// Head entry is visible one cycle after push; requests are refused (lost) while full and drain on wr_ready.
module regwb_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  in_addy,
  input  logic [31:0] in_data,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count,
  output logic        cu_writeReg,
  output logic [4:0]  writeAddy,
  output logic [31:0] writeData,
  input  logic        wr_ready,
  input  logic [4:0]  readAddy1,
  input  logic [4:0]  readAddy2,
  output logic        hit1,
  output logic        hit2,
  output logic [31:0] byp1,
  output logic [31:0] byp2
);

  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic [4:0]  addy_q [4];
  logic [4:0]  addy_d [4];
  logic [31:0] data_q [4];
  logic [31:0] data_d [4];
  logic        push, pop;
  logic [1:0]  idx;

  // Writes to x0 are architecturally meaningless, so they never occupy a slot.
  always_comb begin
    push = in_valid && !full_q && (in_addy != 5'd0);
    pop  = !empty_q && wr_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    addy_d  = addy_q;
    data_d  = data_q;
    count_d = count_q;
    if (push) begin
      addy_d[tail_q] = in_addy;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + 2'd1;
    end
    if (pop) begin
      head_d = head_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == 3'd4);
    empty_d = (count_d == 3'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Payload needs no reset: every reader qualifies slots by count_q.
  always_ff @(posedge clock) begin
    addy_q <= addy_d;
    data_q <= data_d;
  end

  always_comb begin
    full        = full_q;
    empty       = empty_q;
    count       = count_q;
    cu_writeReg = !empty_q;
    writeAddy   = empty_q ? 5'd0  : addy_q[head_q];
    writeData   = empty_q ? 32'd0 : data_q[head_q];
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = 32'd0;
    byp2 = 32'd0;
    idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = head_q + 2'(k);
      if (3'(k) < count_q) begin
        if ((readAddy1 != 5'd0) && (addy_q[idx] == readAddy1)) begin
          hit1 = 1'b1;
          byp1 = data_q[idx];
        end
        if ((readAddy2 != 5'd0) && (addy_q[idx] == readAddy2)) begin
          hit2 = 1'b1;
          byp2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regwb_buffer.sv
// Bench for regwb_buffer: directed scenarios plus random traffic against a queue model.
module tb_regwb_buffer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_addy;
  logic [31:0] in_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        cu_writeReg;
  logic [4:0]  writeAddy;
  logic [31:0] writeData;
  logic        wr_ready;
  logic [4:0]  readAddy1;
  logic [4:0]  readAddy2;
  logic        hit1;
  logic        hit2;
  logic [31:0] byp1;
  logic [31:0] byp2;

  int checks = 0;
  int errors = 0;

  logic [4:0]  mq_a [$];
  logic [31:0] mq_d [$];

  regwb_buffer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_addy(in_addy), .in_data(in_data),
    .full(full), .empty(empty), .count(count),
    .cu_writeReg(cu_writeReg), .writeAddy(writeAddy), .writeData(writeData),
    .wr_ready(wr_ready),
    .readAddy1(readAddy1), .readAddy2(readAddy2),
    .hit1(hit1), .hit2(hit2), .byp1(byp1), .byp2(byp2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic lookup(input logic [4:0] ra, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (ra != 5'd0)
      for (int i = 0; i < mq_a.size(); i++)
        if (mq_a[i] == ra) begin
          h = 1'b1;
          d = mq_d[i];
        end
  endtask

  task automatic model_check();
    logic        h;
    logic [31:0] d;
    int          n;
    n = mq_a.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 4));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("cu_writeReg", 32'(cu_writeReg), 32'(n != 0));
    chk("writeAddy", 32'(writeAddy), (n != 0) ? 32'(mq_a[0]) : 32'd0);
    chk("writeData", writeData, (n != 0) ? mq_d[0] : 32'd0);
    lookup(readAddy1, h, d);
    chk("hit1", 32'(hit1), 32'(h));
    chk("byp1", byp1, d);
    lookup(readAddy2, h, d);
    chk("hit2", 32'(hit2), 32'(h));
    chk("byp2", byp2, d);
  endtask

  task automatic model_edge();
    bit do_push;
    bit do_pop;
    if (reset) begin
      mq_a.delete();
      mq_d.delete();
    end else begin
      do_push = in_valid && (mq_a.size() < 4) && (in_addy != 5'd0);
      do_pop  = (mq_a.size() != 0) && wr_ready;
      if (do_pop) begin
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
      end
      if (do_push) begin
        mq_a.push_back(in_addy);
        mq_d.push_back(in_data);
      end
    end
  endtask

  // Check outputs mid-cycle, then advance model and DUT together through one edge.
  task automatic step();
    @(negedge clock);
    model_check();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic rdy);
    in_valid = v;
    in_addy  = a;
    in_data  = d;
    wr_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    readAddy1 = 5'd0;
    readAddy2 = 5'd0;
    @(posedge clock);
    #1;
    mq_a.delete();
    mq_d.delete();
    step();
    reset = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_cu", 32'(cu_writeReg), 32'd0);
    step();

    // Basic path
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    chk("b_count", 32'(count), 32'd1);
    chk("b_cu", 32'(cu_writeReg), 32'd1);
    chk("b_addy", 32'(writeAddy), 32'd5);
    chk("b_data", writeData, 32'hDEADBEEF);
    step();
    wr_ready = 1'b1;
    step();
    chk("b_empty", 32'(empty), 32'd1);
    chk("b_cu0", 32'(cu_writeReg), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 4) ? 5'd6 : 5'(i + 1), 32'(100 + i), 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    chk("f_full", 32'(full), 32'd1);
    chk("f_count", 32'(count), 32'd4);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("f_drain_addy", 32'(writeAddy), 32'(i + 1));
      step();
    end
    chk("f_empty", 32'(empty), 32'd1);

    // Bypass youngest match
    drive(1'b1, 5'd7, 32'h11, 1'b0);
    step();
    drive(1'b1, 5'd7, 32'h22, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    readAddy1 = 5'd7;
    readAddy2 = 5'd0;
    #1;
    chk("y_hit1", 32'(hit1), 32'd1);
    chk("y_byp1", byp1, 32'h22);
    chk("y_hit2", 32'(hit2), 32'd0);
    wr_ready = 1'b1;
    step();
    chk("y_pop1_byp1", byp1, 32'h22);
    step();
    chk("y_gone_hit1", 32'(hit1), 32'd0);
    chk("y_gone_byp1", byp1, 32'd0);

    // x0 drop, then continuous push/pop at depth 2
    drive(1'b1, 5'd0, 32'hFF, 1'b0);
    step();
    chk("x0_count", 32'(count), 32'd0);
    drive(1'b1, 5'd3, 32'd100, 1'b0);
    step();
    drive(1'b1, 5'd3, 32'd101, 1'b0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 5'd9, 32'(i), 1'b1);
      chk("pp_data", writeData, (i <= 2) ? 32'(99 + i) : 32'(i - 2));
      step();
      chk("pp_count", 32'(count), 32'd2);
    end

    // Reset mid-operation
    drive(1'b1, 5'd12, 32'hC0C0, 1'b0);
    step();
    chk("r_count3", 32'(count), 32'd3);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    readAddy1 = 5'd9;
    readAddy2 = 5'd12;
    #1;
    chk("r_count", 32'(count), 32'd0);
    chk("r_empty", 32'(empty), 32'd1);
    chk("r_cu", 32'(cu_writeReg), 32'd0);
    chk("r_hit1", 32'(hit1), 32'd0);
    chk("r_hit2", 32'(hit2), 32'd0);
    wr_ready = 1'b1;
    step();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_addy   = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      wr_ready  = ($urandom_range(0, 99) < 45);
      readAddy1 = 5'($urandom_range(0, 7));
      readAddy2 = 5'($urandom_range(0, 7));
      reset     = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    for (int c = 0; c < 6; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
